regfile_dump_ctrl: RTL and testbench

Parametrised successor to the 16x8 register file. It provides one write port and two synchronous read ports, one of which feeds the ALU. It also has a dump engine that streams every register out, in index order, over a valid/ready handshake. It sits between the control unit (load/dump strobes) and the ALU/debug output path.

---
 rtl/regfile_dump_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_regfile_dump_ctrl.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_dump_ctrl
// Parametrised register file with one write port and two registered read
// ports (A for general use, B for the ALU), plus a dump engine that streams
// every register out in index order over a valid/ready handshake.
//
// Optional build macro: REGFILE_BYPASS_EN
//   defined   -> same-edge write data is forwarded to the read ports and to the
//                dump data register loaded in LOAD
//   undefined -> reads during a same-index write return the old value
// -----------------------------------------------------------------------------
module regfile_dump_ctrl #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              LoadReg,
    input  logic [ADDR_W-1:0] WrNumber,
    input  logic [WIDTH-1:0]  in,
    input  logic [ADDR_W-1:0] RdNumberA,
    input  logic [ADDR_W-1:0] RdNumberB,
    output logic [WIDTH-1:0]  out,
    output logic [WIDTH-1:0]  out_alu,
    input  logic              DumpReg,
    output logic              dump_valid,
    input  logic              dump_ready,
    output logic [ADDR_W-1:0] dump_index,
    output logic [WIDTH-1:0]  dump_data,
    output logic              dump_busy,
    output logic              dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ONE_IDX  = ADDR_W'(1);

    // Storage view: one element per implemented register.
    logic [WIDTH-1:0]  mem_s [DEPTH];

    // Read-mux results (combinational).
    logic [WIDTH-1:0]  rd_a_s;
    logic [WIDTH-1:0]  rd_b_s;
    logic [WIDTH-1:0]  rd_d_s;
    logic              wr_in_range_s;

    // FSM and dump datapath.
    state_t            state_r;
    state_t            state_next_s;
    logic [ADDR_W-1:0] dump_index_r;
    logic [ADDR_W-1:0] dump_index_next_s;
    logic [WIDTH-1:0]  dump_data_r;
    logic [WIDTH-1:0]  dump_data_next_s;
    logic              dump_valid_r;
    logic              dump_busy_r;
    logic              dump_done_r;

    // Read port registers.
    logic [WIDTH-1:0]  out_r;
    logic [WIDTH-1:0]  out_alu_r;

    // Out-of-range write indices have no register behind them and are dropped.
    assign wr_in_range_s = (32'(WrNumber) < 32'(DEPTH));

    // One register per index; each only responds to its own write index.
    genvar g;
    for (g = 0; g < DEPTH; g++) begin : g_reg
        localparam logic [ADDR_W-1:0] IDX = ADDR_W'(g);
        logic [WIDTH-1:0] q_r;

        // Register storage: cleared on reset, loaded on a matching write.
        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                q_r <= '0;
            end else if (LoadReg && (WrNumber == IDX)) begin
                q_r <= in;
            end
        end

        assign mem_s[g] = q_r;
    end

    // Read muxes for port A, port B and the dump engine; unmatched indices read 0.
    always_comb begin
        rd_a_s = '0;
        rd_b_s = '0;
        rd_d_s = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rd_a_s = rd_a_s | ((RdNumberA    == ADDR_W'(i)) ? mem_s[i] : '0);
            rd_b_s = rd_b_s | ((RdNumberB    == ADDR_W'(i)) ? mem_s[i] : '0);
            rd_d_s = rd_d_s | ((dump_index_r == ADDR_W'(i)) ? mem_s[i] : '0);
        end
`ifdef REGFILE_BYPASS_EN
        // Forward the value being written this edge so readers see new data.
        if (LoadReg && wr_in_range_s && (WrNumber == RdNumberA)) begin
            rd_a_s = in;
        end else begin
            rd_a_s = rd_a_s;
        end
        if (LoadReg && wr_in_range_s && (WrNumber == RdNumberB)) begin
            rd_b_s = in;
        end else begin
            rd_b_s = rd_b_s;
        end
        if (LoadReg && wr_in_range_s && (WrNumber == dump_index_r)) begin
            rd_d_s = in;
        end else begin
            rd_d_s = rd_d_s;
        end
`endif
    end

    // Read ports: one-cycle registered latency, independent of the dump engine.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_r     <= '0;
            out_alu_r <= '0;
        end else begin
            out_r     <= rd_a_s;
            out_alu_r <= rd_b_s;
        end
    end

    // Dump FSM next-state and datapath: each beat costs a LOAD and a STREAM cycle.
    always_comb begin
        state_next_s      = state_r;
        dump_index_next_s = dump_index_r;
        dump_data_next_s  = dump_data_r;
        case (state_r)
            ST_IDLE: begin
                if (DumpReg) begin
                    dump_index_next_s = '0;
                    state_next_s      = ST_LOAD;
                end else begin
                    state_next_s      = ST_IDLE;
                end
            end
            ST_LOAD: begin
                dump_data_next_s = rd_d_s;
                state_next_s     = ST_STREAM;
            end
            ST_STREAM: begin
                if (dump_ready) begin
                    if (dump_index_r == LAST_IDX) begin
                        state_next_s = ST_DONE;
                    end else begin
                        dump_index_next_s = dump_index_r + ONE_IDX;
                        state_next_s      = ST_LOAD;
                    end
                end else begin
                    state_next_s = ST_STREAM;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // Dump FSM state and registered handshake outputs derived from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= ST_IDLE;
            dump_index_r <= '0;
            dump_data_r  <= '0;
            dump_valid_r <= 1'b0;
            dump_busy_r  <= 1'b0;
            dump_done_r  <= 1'b0;
        end else begin
            state_r      <= state_next_s;
            dump_index_r <= dump_index_next_s;
            dump_data_r  <= dump_data_next_s;
            dump_valid_r <= (state_next_s == ST_STREAM);
            dump_busy_r  <= (state_next_s == ST_LOAD) || (state_next_s == ST_STREAM);
            dump_done_r  <= (state_next_s == ST_DONE);
        end
    end

    assign out        = out_r;
    assign out_alu    = out_alu_r;
    assign dump_valid = dump_valid_r;
    assign dump_index = dump_index_r;
    assign dump_data  = dump_data_r;
    assign dump_busy  = dump_busy_r;
    assign dump_done  = dump_done_r;

endmodule

// File: tb/tb_regfile_dump_ctrl.sv
// -----------------------------------------------------------------------------
// Directed testbench for regfile_dump_ctrl (WIDTH=8, DEPTH=16, ADDR_W=5 so that
// an out-of-range index exists). Honours REGFILE_BYPASS_EN when defined.
// -----------------------------------------------------------------------------
module tb_regfile_dump_ctrl;

    localparam int WIDTH  = 8;
    localparam int DEPTH  = 16;
    localparam int ADDR_W = 5;

    logic              clk = 1'b0;
    logic              reset;
    logic              LoadReg;
    logic [ADDR_W-1:0] WrNumber;
    logic [WIDTH-1:0]  in;
    logic [ADDR_W-1:0] RdNumberA;
    logic [ADDR_W-1:0] RdNumberB;
    logic [WIDTH-1:0]  out;
    logic [WIDTH-1:0]  out_alu;
    logic              DumpReg;
    logic              dump_valid;
    logic              dump_ready;
    logic [ADDR_W-1:0] dump_index;
    logic [WIDTH-1:0]  dump_data;
    logic              dump_busy;
    logic              dump_done;

    int total = 0;
    int bad   = 0;

    regfile_dump_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk        (clk),
        .reset      (reset),
        .LoadReg    (LoadReg),
        .WrNumber   (WrNumber),
        .in         (in),
        .RdNumberA  (RdNumberA),
        .RdNumberB  (RdNumberB),
        .out        (out),
        .out_alu    (out_alu),
        .DumpReg    (DumpReg),
        .dump_valid (dump_valid),
        .dump_ready (dump_ready),
        .dump_index (dump_index),
        .dump_data  (dump_data),
        .dump_busy  (dump_busy),
        .dump_done  (dump_done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] rdw_exp;
        bit         seen;

        reset = 1'b1; LoadReg = 1'b0; WrNumber = '0; in = '0;
        RdNumberA = '0; RdNumberB = '0; DumpReg = 1'b0; dump_ready = 1'b0;
        step(); step();
        chk("rst_out", 32'(out), 32'h0);
        chk("rst_out_alu", 32'(out_alu), 32'h0);
        chk("rst_valid", 32'(dump_valid), 32'h0);
        chk("rst_busy", 32'(dump_busy), 32'h0);
        chk("rst_done", 32'(dump_done), 32'h0);
        chk("rst_index", 32'(dump_index), 32'h0);
        chk("rst_data", 32'(dump_data), 32'h0);
        reset = 1'b0;

        // 1: all registers read zero on both ports
        for (int i = 0; i < DEPTH; i++) begin
            RdNumberA = ADDR_W'(i);
            RdNumberB = ADDR_W'(DEPTH - 1 - i);
            step();
            chk("t1_out", 32'(out), 32'h0);
            chk("t1_alu", 32'(out_alu), 32'h0);
            chk("t1_busy", 32'(dump_busy), 32'h0);
            chk("t1_valid", 32'(dump_valid), 32'h0);
        end

        // 2: basic write/read, top index, dropped out-of-range write
        LoadReg = 1'b1; WrNumber = 5'd1; in = 8'hCC;
        step();
        LoadReg = 1'b0; RdNumberA = 5'd1; RdNumberB = 5'd1;
        step();
        chk("t2_out_1", 32'(out), 32'hCC);
        chk("t2_alu_1", 32'(out_alu), 32'hCC);
        LoadReg = 1'b1; WrNumber = 5'd15; in = 8'hF0;
        step();
        LoadReg = 1'b0; RdNumberA = 5'd15; RdNumberB = 5'd1;
        step();
        chk("t2_out_15", 32'(out), 32'hF0);
        chk("t2_alu_1b", 32'(out_alu), 32'hCC);
        LoadReg = 1'b1; WrNumber = 5'd16; in = 8'h5A;
        step();
        LoadReg = 1'b0; RdNumberA = 5'd16; RdNumberB = 5'd0;
        step();
        chk("t2_out_16", 32'(out), 32'h0);
        chk("t2_alu_0", 32'(out_alu), 32'h0);

        // 3: read-during-write on the same index
        LoadReg = 1'b1; WrNumber = 5'd3; in = 8'h11;
        step();
        WrNumber = 5'd3; in = 8'hAA; RdNumberA = 5'd3; RdNumberB = 5'd3;
        step();
`ifdef REGFILE_BYPASS_EN
        rdw_exp = 8'hAA;
`else
        rdw_exp = 8'h11;
`endif
        chk("t3_rdw_out", 32'(out), 32'(rdw_exp));
        chk("t3_rdw_alu", 32'(out_alu), 32'(rdw_exp));
        LoadReg = 1'b0;
        step();
        chk("t3_after", 32'(out), 32'hAA);

        // 4: preload and full dump with ready held high
        for (int i = 0; i < DEPTH; i++) begin
            LoadReg = 1'b1; WrNumber = ADDR_W'(i); in = 8'(8'h10 + i);
            step();
        end
        LoadReg = 1'b0;
        dump_ready = 1'b1; DumpReg = 1'b1;
        step();
        DumpReg = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            chk("t4_load_busy", 32'(dump_busy), 32'h1);
            chk("t4_load_valid", 32'(dump_valid), 32'h0);
            chk("t4_load_index", 32'(dump_index), 32'(i));
            step();
            chk("t4_str_valid", 32'(dump_valid), 32'h1);
            chk("t4_str_index", 32'(dump_index), 32'(i));
            chk("t4_str_data", 32'(dump_data), 32'(8'h10 + i));
            chk("t4_str_done", 32'(dump_done), 32'h0);
            step();
        end
        chk("t4_done", 32'(dump_done), 32'h1);
        chk("t4_done_busy", 32'(dump_busy), 32'h0);
        chk("t4_done_valid", 32'(dump_valid), 32'h0);
        step();
        chk("t4_done_pulse", 32'(dump_done), 32'h0);
        chk("t4_idle_busy", 32'(dump_busy), 32'h0);

        // 5: backpressure at index 4 with writes during the dump
        dump_ready = 1'b0; DumpReg = 1'b1;
        step();
        DumpReg = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            dump_ready = 1'b1;
            step();
            dump_ready = 1'b0;
        end
        step();
        chk("t5_idx4", 32'(dump_index), 32'h4);
        chk("t5_data4", 32'(dump_data), 32'h14);
        LoadReg = 1'b1; WrNumber = 5'd4; in = 8'hEE;
        for (int c = 0; c < 5; c++) begin
            step();
            if (c == 0) begin
                WrNumber = 5'd6; in = 8'h66;
            end else begin
                LoadReg = 1'b0;
            end
            chk("t5_hold_valid", 32'(dump_valid), 32'h1);
            chk("t5_hold_index", 32'(dump_index), 32'h4);
            chk("t5_hold_data", 32'(dump_data), 32'h14);
        end
        RdNumberA = 5'd4;
        dump_ready = 1'b1;
        step();
        chk("t5_load5_index", 32'(dump_index), 32'h5);
        chk("t5_load5_valid", 32'(dump_valid), 32'h0);
        step();
        chk("t5_mem4", 32'(out), 32'hEE);
        chk("t5_str5_data", 32'(dump_data), 32'h15);
        step();
        step();
        chk("t5_str6_index", 32'(dump_index), 32'h6);
        chk("t5_str6_data", 32'(dump_data), 32'h66);
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            step();
            seen = dump_done;
        end
        chk("t5_done_seen", 32'(seen), 32'h1);
        step();

        // 6: DumpReg held high during a dump, then reset at index 7
        DumpReg = 1'b1; dump_ready = 1'b1;
        step();
        for (int i = 0; i < 7; i++) begin
            chk("t6_load_index", 32'(dump_index), 32'(i));
            step();
            chk("t6_str_index", 32'(dump_index), 32'(i));
            step();
        end
        step();
        chk("t6_pre_index", 32'(dump_index), 32'h7);
        chk("t6_pre_valid", 32'(dump_valid), 32'h1);
        reset = 1'b1;
        #1;
        chk("t6_rst_valid", 32'(dump_valid), 32'h0);
        chk("t6_rst_busy", 32'(dump_busy), 32'h0);
        chk("t6_rst_index", 32'(dump_index), 32'h0);
        chk("t6_rst_data", 32'(dump_data), 32'h0);
        chk("t6_rst_done", 32'(dump_done), 32'h0);
        chk("t6_rst_out", 32'(out), 32'h0);
        DumpReg = 1'b0;
        step();
        chk("t6_rst_done2", 32'(dump_done), 32'h0);
        reset = 1'b0;
        RdNumberA = 5'd4; RdNumberB = 5'd6;
        step();
        chk("t6_mem4", 32'(out), 32'h0);
        chk("t6_mem6", 32'(out_alu), 32'h0);
        chk("t6_idle_done", 32'(dump_done), 32'h0);
        chk("t6_idle_busy", 32'(dump_busy), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
